pipeline_hazard_ctrl: RTL and testbench

Hazard/sequencing controller for the 5-stage MIPS pipeline. It drives write-enable and flush controls for the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards between the ID and EX stages.
- Squashes wrong-path instructions on a taken branch resolved in EX.
- Tracks a multi-cycle mult/div unit with an internal busy timer.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/md_busy_timer.sv | 50 +++++
 rtl/pipeline_hazard_ctrl.sv | 83 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants.
// Imported by the hazard controller and the pipeline register modules.
package pipe_ctrl_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int NOP_EX_W = 5;
  localparam int NOP_M_W  = 3;
  localparam int NOP_WB_W = 2;

  function automatic int md_cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy tracker: MD_LAT busy cycles per accepted start.
// The unit is older than any branch, so nothing but reset cancels it.
module md_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start_accept,
  output logic busy
);

  localparam int W = md_cnt_w(MD_LAT);

  md_state_t      state;
  logic [W-1:0]   md_cnt;

  // Busy FSM with countdown; idles after the cycle where md_cnt is 1.
  always_ff @(negedge clk) begin
    if (!reset) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (start_accept) begin
            state  <= MD_BUSY;
            md_cnt <= W'(MD_LAT);
          end
        end
        MD_BUSY: begin
          if (md_cnt == W'(1)) begin
            state  <= MD_IDLE;
            md_cnt <= '0;
          end else begin
            md_cnt <= md_cnt - W'(1);
          end
        end
        default: begin
          state  <= MD_IDLE;
          md_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline.
// Priority: taken branch, then mult/div stall, then load-use stall.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = 8,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          id_uses_rt,
  input  logic          ex_mem_read,
  input  logic [4:0]    ex_rt,
  input  logic          ex_branch_taken,
  input  logic          id_md_start,
  input  logic          id_md_use,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          if_id_flush,
  output logic          id_ex_flush,
  output logic          md_busy,
  output logic [CW-1:0] stall_count
);

  logic lu_haz;
  logic md_haz;
  logic md_run;
  logic start_accept;

  assign lu_haz = ex_mem_read
                & (ex_rt != REG_ZERO)
                & ((ex_rt == id_rs)
                 | (id_uses_rt & (ex_rt == id_rt)));

  assign md_haz = md_run & (id_md_start | id_md_use);

  // A start advances to EX only when idle, unsquashed and unstalled.
  assign start_accept = id_md_start
                      & ~ex_branch_taken
                      & ~lu_haz
                      & ~md_run;

  md_busy_timer #(
    .MD_LAT(MD_LAT)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .start_accept(start_accept),
    .busy        (md_run)
  );

  // Pipeline register controls; a taken branch squashes any ID hazard.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!reset) begin
      pc_write    = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (md_haz | lu_haz) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign md_busy = reset & md_run;

  // Saturating count of cycles the PC was held.
  always_ff @(negedge clk) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != {CW{1'b1}})) begin
      stall_count <= stall_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MD_LAT=8, CW=4).
// Reference model tracks the cycle at which mult/div frees up.
module tb_pipeline_hazard_ctrl;

  localparam int MD_LAT = 8;
  localparam int CW     = 4;
  localparam int SMAX   = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic          id_uses_rt;
  logic          ex_mem_read;
  logic [4:0]    ex_rt;
  logic          ex_branch_taken;
  logic          id_md_start;
  logic          id_md_use;
  logic          pc_write;
  logic          if_id_write;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          md_busy;
  logic [CW-1:0] stall_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_end = 0;
  int stalls = 0;

  pipeline_hazard_ctrl #(
    .MD_LAT(MD_LAT),
    .CW    (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .ex_mem_read    (ex_mem_read),
    .ex_rt          (ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .id_md_start    (id_md_start),
    .id_md_use      (id_md_use),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .md_busy        (md_busy),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic rst,
                     input logic [4:0] rs,
                     input logic [4:0] rt,
                     input logic urt,
                     input logic mr,
                     input logic [4:0] xrt,
                     input logic br,
                     input logic st,
                     input logic us);
    reset           = rst;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = urt;
    ex_mem_read     = mr;
    ex_rt           = xrt;
    ex_branch_taken = br;
    id_md_start     = st;
    id_md_use       = us;
  endtask

  // Check mid-cycle, then advance the model across the falling edge.
  task automatic tick(input bit do_chk);
    bit lu, md, bs;
    logic ep, ei, ef, ex, eb;
    @(posedge clk);
    #1;
    bs = (cyc < busy_end);
    lu = ex_mem_read && (ex_rt != 0)
         && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    md = bs && (id_md_start || id_md_use);
    ep = 1; ei = 1; ef = 0; ex = 0; eb = bs;
    if (!reset) begin
      eb = 0;
    end else if (ex_branch_taken) begin
      ef = 1; ex = 1;
    end else if (md || lu) begin
      ep = 0; ei = 0; ex = 1;
    end
    if (do_chk) begin
      chk("pc_write", {15'd0, pc_write}, {15'd0, ep});
      chk("if_id_write", {15'd0, if_id_write}, {15'd0, ei});
      chk("if_id_flush", {15'd0, if_id_flush}, {15'd0, ef});
      chk("id_ex_flush", {15'd0, id_ex_flush}, {15'd0, ex});
      chk("md_busy", {15'd0, md_busy}, {15'd0, eb});
      chk("stall_count", {12'd0, stall_count}, 16'(stalls));
    end
    @(negedge clk);
    if (!reset) begin
      busy_end = 0;
      stalls   = 0;
    end else begin
      if (!ep) stalls = (stalls < SMAX) ? stalls + 1 : SMAX;
      if (id_md_start && !ex_branch_taken && !lu && !bs)
        busy_end = cyc + 1 + MD_LAT;
    end
    cyc++;
    #1;
  endtask

  task automatic idle;
    drv(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic do_reset;
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    tick(1);
  endtask

  initial begin
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    tick(0);
    tick(1);

    // load-use on rs
    idle; tick(1);
    drv(1, 5'd8, 5'd3, 0, 1, 5'd8, 0, 0, 0); tick(1);
    idle; tick(1);
    chk("lu_count", {12'd0, stall_count}, 16'd1);
    // ex_rt zero never hazards
    drv(1, 5'd0, 5'd3, 1, 1, 5'd0, 0, 0, 0); tick(1);
    // rt-only dependency
    drv(1, 5'd4, 5'd9, 0, 1, 5'd9, 0, 0, 0); tick(1);
    drv(1, 5'd4, 5'd9, 1, 1, 5'd9, 0, 0, 0); tick(1);
    idle; tick(1);
    chk("rt_count", {12'd0, stall_count}, 16'd2);

    // mult/div then mfhi from third busy cycle
    do_reset;
    drv(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0); tick(1);
    idle; tick(1); tick(1);
    for (int i = 0; i < 7; i++) begin
      drv(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1); tick(1);
    end
    chk("md_count", {12'd0, stall_count}, 16'd6);
    // back-to-back starts
    drv(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0); tick(1);
    for (int i = 0; i < MD_LAT + 2; i++) tick(1);
    idle; tick(1);

    // branch beats load-use
    do_reset;
    drv(1, 5'd7, 5'd3, 0, 1, 5'd7, 1, 0, 0); tick(1);
    chk("br_count", {12'd0, stall_count}, 16'd0);
    // branch squashes start in idle
    drv(1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0); tick(1);
    idle; tick(1);
    chk("br_md_busy", {15'd0, md_busy}, 16'd0);

    // reset mid-busy at md_cnt=5
    drv(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0); tick(1);
    drv(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1); tick(1); tick(1); tick(1);
    do_reset;
    idle; tick(1);
    chk("rst_busy", {15'd0, md_busy}, 16'd0);

    // saturation
    for (int i = 0; i < 20; i++) begin
      drv(1, 5'd6, 5'd0, 0, 1, 5'd6, 0, 0, 0); tick(1);
    end
    chk("sat_count", {12'd0, stall_count}, 16'(SMAX));

    // random traffic
    do_reset;
    for (int i = 0; i < 400; i++) begin
      drv(($urandom_range(0, 39) != 0),
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 4) == 0));
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
